// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and widths.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_BURST = 2'd3
  } led_mode_e;

  // Channel-select width with one spare code so an out-of-range target is representable.
  function automatic int ch_sel_w(input int num_ch);
    return (num_ch < 1) ? 1 : $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/timing registers, phase and burst counters, registered pin and done pulse.
module led_channel
  import led_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4,
  parameter bit ACT_LO  = 1'b0
) (
  input  logic               CLK_IN,
  input  logic               rst,
  input  logic               tick,
  input  logic               sync,
  input  logic               wr,
  input  logic [MODE_W-1:0]  wr_mode,
  input  logic [CNT_W-1:0]   wr_period,
  input  logic [CNT_W-1:0]   wr_on,
  input  logic [BURST_W-1:0] wr_burst,
  output logic               pin,
  output logic               done
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W:0]   BURST_ONE = (BURST_W + 1)'(1);

  led_mode_e          mode_reg,   mode_next;
  logic [CNT_W-1:0]   period_reg, period_next;
  logic [CNT_W-1:0]   on_reg,     on_next;
  logic [BURST_W-1:0] burst_reg,  burst_next;
  logic [CNT_W-1:0]   phase_reg,  phase_next;
  logic [BURST_W-1:0] bcnt_reg,   bcnt_next;
  logic               pin_reg,    pin_next;
  logic               done_reg,   done_next;

  logic [CNT_W-1:0]   last_phase;
  logic               running;
  logic               at_last;
  logic               wrap;
  logic               finish;
  logic               lit;

  always_comb begin
    mode_next   = mode_reg;
    period_next = period_reg;
    on_next     = on_reg;
    burst_next  = burst_reg;
    phase_next  = phase_reg;
    bcnt_next   = bcnt_reg;
    finish      = 1'b0;
    lit         = 1'b0;

    // A zero period behaves like a one-tick period.
    last_phase = (period_reg == '0) ? '0 : (period_reg - CNT_ONE);
    running    = (mode_reg == LED_BLINK) || (mode_reg == LED_BURST);
    at_last    = (phase_reg >= last_phase);
    wrap       = running && tick && at_last && !sync;

    unique case (mode_reg)
      LED_OFF:   lit = 1'b0;
      LED_ON:    lit = 1'b1;
      LED_BLINK: lit = (phase_reg < on_reg);
      LED_BURST: lit = (burst_reg != '0) && (phase_reg < on_reg);
      default:   lit = 1'b0;
    endcase

    if (running) begin
      if (sync) begin
        phase_next = '0;
      end else if (tick) begin
        phase_next = at_last ? '0 : (phase_reg + CNT_ONE);
      end
    end

    if (mode_reg == LED_BURST) begin
      if (burst_reg == '0) begin
        finish = 1'b1;
      end else if (wrap) begin
        if (({1'b0, bcnt_reg} + BURST_ONE) == {1'b0, burst_reg}) begin
          finish = 1'b1;
        end else begin
          bcnt_next = bcnt_reg + BURST_W'(1);
        end
      end
    end

    if (finish) begin
      mode_next = LED_OFF;
      bcnt_next = '0;
      lit       = 1'b0;
    end

    // A write restarts the channel and suppresses any completion in the same cycle.
    if (wr) begin
      mode_next   = led_mode_e'(wr_mode);
      period_next = wr_period;
      on_next     = wr_on;
      burst_next  = wr_burst;
      phase_next  = '0;
      bcnt_next   = '0;
      finish      = 1'b0;
    end

    pin_next  = lit ^ ACT_LO;
    done_next = finish;
  end

  always_ff @(posedge CLK_IN or negedge rst) begin
    if (!rst) begin
      mode_reg   <= LED_OFF;
      period_reg <= '0;
      on_reg     <= '0;
      burst_reg  <= '0;
      phase_reg  <= '0;
      bcnt_reg   <= '0;
      pin_reg    <= ACT_LO;
      done_reg   <= 1'b0;
    end else begin
      mode_reg   <= mode_next;
      period_reg <= period_next;
      on_reg     <= on_next;
      burst_reg  <= burst_next;
      phase_reg  <= phase_next;
      bcnt_reg   <= bcnt_next;
      pin_reg    <= pin_next;
      done_reg   <= done_next;
    end
  end

  assign pin  = pin_reg;
  assign done = done_reg;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler plus one led_channel per LED.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 8,
  parameter int BURST_W    = 4,
  parameter int PRESCALE   = 200,
  parameter int LED_ACT_LO = 0,
  localparam int CH_W      = ch_sel_w(NUM_CH)
) (
  input  logic               CLK_IN,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [MODE_W-1:0]  cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_on,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               sync_all,
  output logic [NUM_CH-1:0]  LED_OUT,
  output logic [NUM_CH-1:0]  burst_done
);

  localparam int            PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0]  pre_reg, pre_next;
  logic              tick;
  logic [NUM_CH-1:0] wr_sel;

  always_comb begin
    tick     = (pre_reg == PRE_LAST);
    pre_next = tick ? '0 : (pre_reg + PRE_ONE);
  end

  always_ff @(posedge CLK_IN or negedge rst) begin
    if (!rst) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Targets at or above NUM_CH never match, so such writes fall on the floor.
      assign wr_sel[gi] = cfg_we && (cfg_ch == CH_W'(gi));

      led_channel #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W),
        .ACT_LO  (LED_ACT_LO != 0)
      ) u_ch (
        .CLK_IN    (CLK_IN),
        .rst       (rst),
        .tick      (tick),
        .sync      (sync_all),
        .wr        (wr_sel[gi]),
        .wr_mode   (cfg_mode),
        .wr_period (cfg_period),
        .wr_on     (cfg_on),
        .wr_burst  (cfg_burst),
        .pin       (LED_OUT[gi]),
        .done      (burst_done[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a queue scoreboard; an active-low build runs alongside.
module tb_led_pattern_gen;
  import led_pkg::*;

  logic       CLK_IN = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_period;
  logic [7:0] cfg_on;
  logic [3:0] cfg_burst;
  logic       sync_all;
  logic [1:0] LED_OUT, burst_done;
  logic [1:0] led_lo, done_lo;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  typedef struct {
    string      tag;
    logic [1:0] led;
    logic [1:0] done;
  } exp_t;
  exp_t sb[$];

  led_pattern_gen #(.NUM_CH(2), .CNT_W(8), .BURST_W(4), .PRESCALE(4), .LED_ACT_LO(0)) dut (
    .CLK_IN(CLK_IN), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_on(cfg_on), .cfg_burst(cfg_burst), .sync_all(sync_all),
    .LED_OUT(LED_OUT), .burst_done(burst_done)
  );

  led_pattern_gen #(.NUM_CH(2), .CNT_W(8), .BURST_W(4), .PRESCALE(4), .LED_ACT_LO(1)) dut_lo (
    .CLK_IN(CLK_IN), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_on(cfg_on), .cfg_burst(cfg_burst), .sync_all(sync_all),
    .LED_OUT(led_lo), .burst_done(done_lo)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Edges seen since reset release; the prescaler is at cyc % 4.
  always @(posedge CLK_IN or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic plan(input string tag, input logic [1:0] led, input logic [1:0] done, input int n);
    exp_t e;
    e.tag = tag; e.led = led; e.done = done;
    repeat (n) sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_empty: got output with no expectation queued, want one queued");
      return;
    end
    e = sb.pop_front();
    n_cmp += 4;
    assert (LED_OUT === e.led) else begin
      n_bad++; $error("FAIL %s LED_OUT got %b want %b", e.tag, LED_OUT, e.led);
    end
    assert (burst_done === e.done) else begin
      n_bad++; $error("FAIL %s burst_done got %b want %b", e.tag, burst_done, e.done);
    end
    assert (led_lo === ~e.led) else begin
      n_bad++; $error("FAIL %s LED_OUT(act_lo) got %b want %b", e.tag, led_lo, ~e.led);
    end
    assert (done_lo === e.done) else begin
      n_bad++; $error("FAIL %s burst_done(act_lo) got %b want %b", e.tag, done_lo, e.done);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge CLK_IN);
      @(negedge CLK_IN);
      compare_front();
    end
  endtask

  task automatic check_now(input string tag, input logic [1:0] led, input logic [1:0] done);
    plan(tag, led, done, 1);
    compare_front();
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  // With align set, the sampling edge leaves the prescaler at 0.
  task automatic drive(input logic we, input logic [1:0] ch, input logic [1:0] mode,
                       input logic [7:0] per, input logic [7:0] on, input logic [3:0] burst,
                       input logic sync, input logic align);
    if (align) begin
      while (((cyc + 1) % 4) != 0) @(negedge CLK_IN);
    end
    cfg_we = we; cfg_ch = ch; cfg_mode = mode; cfg_period = per;
    cfg_on = on; cfg_burst = burst; sync_all = sync;
    @(posedge CLK_IN);
    #1;
    cfg_we = 1'b0; sync_all = 1'b0;
    @(negedge CLK_IN);
    $display("txn t=%0t we=%0b ch=%0d mode=%0d period=%0d on=%0d burst=%0d sync=%0b",
             $time, we, ch, mode, per, on, burst, sync);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_on = '0; cfg_burst = '0; sync_all = 1'b0;
    repeat (3) @(negedge CLK_IN);
    check_now("reset", 2'b00, 2'b00);
    rst = 1'b1;

    // ON mode: lit from the edge after the write.
    drive(1'b1, 2'd0, LED_ON, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0);
    check_now("on_k", 2'b00, 2'b00);
    plan("on_k1", 2'b01, 2'b00, 3);
    run(3);

    // Asynchronous reset with no clock edge.
    #2 rst = 1'b0;
    #1 check_now("async_rst", 2'b00, 2'b00);
    @(negedge CLK_IN);
    rst = 1'b1;

    // BLINK period 5, on 2: 8 lit, 12 dark.
    drive(1'b1, 2'd0, LED_BLINK, 8'd5, 8'd2, 4'd0, 1'b0, 1'b1);
    check_now("blink_k", 2'b00, 2'b00);
    plan("blink_on", 2'b01, 2'b00, 8);  plan("blink_off", 2'b00, 2'b00, 12);
    plan("blink_on", 2'b01, 2'b00, 8);  plan("blink_off", 2'b00, 2'b00, 12);
    run(40);

    // Duty edge cases.
    drive(1'b1, 2'd0, LED_BLINK, 8'd5, 8'd0, 4'd0, 1'b0, 1'b0);
    plan("on0", 2'b00, 2'b00, 24);         run(24);
    drive(1'b1, 2'd0, LED_BLINK, 8'd5, 8'd7, 4'd0, 1'b0, 1'b0);
    plan("on_ge_period", 2'b01, 2'b00, 24); run(24);
    drive(1'b1, 2'd0, LED_OFF, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0);
    plan("off", 2'b00, 2'b00, 2);           run(2);
    drive(1'b1, 2'd0, LED_BLINK, 8'd0, 8'd1, 4'd0, 1'b0, 1'b0);
    plan("period0", 2'b01, 2'b00, 24);      run(24);
    drive(1'b1, 2'd0, LED_OFF, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0);
    plan("off", 2'b00, 2'b00, 2);           run(2);

    // BURST ch1 period 2, on 1, burst 3.
    drive(1'b1, 2'd1, LED_BURST, 8'd2, 8'd1, 4'd3, 1'b0, 1'b1);
    check_now("burst_k", 2'b00, 2'b00);
    for (int p = 0; p < 2; p++) begin
      plan("burst_lit", 2'b10, 2'b00, 4); plan("burst_dark", 2'b00, 2'b00, 4);
    end
    plan("burst_lit", 2'b10, 2'b00, 4); plan("burst_dark", 2'b00, 2'b00, 3);
    plan("burst_done", 2'b00, 2'b10, 1); plan("burst_after", 2'b00, 2'b00, 16);
    run(40);

    // BURST with zero count.
    drive(1'b1, 2'd1, LED_BURST, 8'd2, 8'd1, 4'd0, 1'b0, 1'b0);
    check_now("burst0_k", 2'b00, 2'b00);
    plan("burst0_done", 2'b00, 2'b10, 1); plan("burst0_after", 2'b00, 2'b00, 8);
    run(9);

    // Two BLINK channels out of phase, then sync_all.
    drive(1'b1, 2'd0, LED_BLINK, 8'd4, 8'd2, 4'd0, 1'b0, 1'b1);
    check_now("ph_a_k", 2'b00, 2'b00);
    plan("ph_a", 2'b01, 2'b00, 7); run(7);
    drive(1'b1, 2'd1, LED_BLINK, 8'd4, 8'd2, 4'd0, 1'b0, 1'b1);
    check_now("ph_b_k", 2'b01, 2'b00);
    plan("ph_b", 2'b10, 2'b00, 8); plan("ph_b", 2'b01, 2'b00, 8); run(16);
    drive(1'b0, 2'd0, LED_OFF, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1);
    check_now("sync_k", 2'b10, 2'b00);
    plan("synced", 2'b11, 2'b00, 8); plan("synced", 2'b00, 2'b00, 8);
    plan("synced", 2'b11, 2'b00, 8); run(24);

    // Desync ch1, then sync_all together with a ch0 write.
    drive(1'b1, 2'd1, LED_BLINK, 8'd4, 8'd2, 4'd0, 1'b0, 1'b1);
    check_now("rw1_k", 2'b00, 2'b00);
    plan("rw1", 2'b10, 2'b00, 3); run(3);
    drive(1'b1, 2'd0, LED_BLINK, 8'd4, 8'd1, 4'd0, 1'b1, 1'b1);
    check_now("wsync_k", 2'b10, 2'b00);
    plan("wsync", 2'b11, 2'b00, 4); plan("wsync", 2'b10, 2'b00, 4);
    plan("wsync", 2'b00, 2'b00, 8); plan("wsync", 2'b11, 2'b00, 4);
    plan("wsync", 2'b10, 2'b00, 4); run(24);

    // Out-of-range channel write must change nothing.
    drive(1'b1, 2'd2, LED_OFF, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1);
    check_now("guard_k", 2'b00, 2'b00);
    plan("guard", 2'b00, 2'b00, 4); plan("guard", 2'b11, 2'b00, 4);
    plan("guard", 2'b10, 2'b00, 4); run(12);

    // Rewrite mid-BURST at the completing wrap: restart, no done pulse.
    drive(1'b1, 2'd0, LED_OFF, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, LED_BURST, 8'd2, 8'd1, 4'd1, 1'b0, 1'b1);
    plan("rb", 2'b10, 2'b00, 4); plan("rb", 2'b00, 2'b00, 3); run(7);
    drive(1'b1, 2'd1, LED_BURST, 8'd2, 8'd1, 4'd1, 1'b0, 1'b1);
    check_now("rb_k", 2'b00, 2'b00);
    plan("rb2", 2'b10, 2'b00, 4); plan("rb2", 2'b00, 2'b00, 3);
    plan("rb2_done", 2'b00, 2'b10, 1); plan("rb2_after", 2'b00, 2'b00, 4);
    run(12);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++; $error("FAIL sb_leftover got %0d entries want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
